// File: rtl/prog_mem_pkg.sv
// prog_mem_pkg: shared program-memory geometry and loader state encoding,
// used by the loader, the fetch counter and the ROM wrappers.
package prog_mem_pkg;

    localparam int PM_AW = 12;
    localparam int PM_DW = 8;

    typedef enum logic [1:0] {
        LDR_IDLE = 2'd0,
        LDR_LOAD = 2'd1,
        LDR_DONE = 2'd2
    } ldr_state_t;

endpackage

// File: rtl/prog_mem_ram.sv
// prog_mem_ram: 2**AW x DW program RAM, synchronous write, asynchronous read.
module prog_mem_ram #(
    parameter int AW = 12,
    parameter int DW = 8
) (
    input  logic          CLK,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic [AW-1:0] ra,
    output logic [DW-1:0] rd
);

    logic [DW-1:0] mem [2**AW];

    // No reset: loaded code must survive a RESET of the loader.
    always_ff @(posedge CLK)
        if (we) mem[wa] <= wd;

    assign rd = mem[ra];

endmodule

// File: rtl/prog_mem_loader.sv
// prog_mem_loader: streams bytes into program RAM from a base address.
// Optional running checksum enabled by PROG_MEM_LOADER_CSUM_EN.
module prog_mem_loader
    import prog_mem_pkg::*;
#(
    parameter int AW = PM_AW,
    parameter int DW = PM_DW
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW-1:0] len_m1,
    input  logic          abort,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] wr_addr,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic [DW-1:0] csum
);

    ldr_state_t    state, state_nx;
    logic [AW-1:0] remaining;
    logic          launch;
    logic          xfer;

    assign launch   = (state == LDR_IDLE) && start;
    // Abort wins over a same-cycle transfer so the byte is dropped.
    assign xfer     = (state == LDR_LOAD) && in_valid && !abort;
    assign in_ready = (state == LDR_LOAD);
    assign busy     = (state == LDR_LOAD);
    assign done     = (state == LDR_DONE);

    always_ff @(posedge CLK or posedge RESET)
        if (RESET) begin
            state     <= LDR_IDLE;
            wr_addr   <= '0;
            remaining <= '0;
        end else begin
            state <= state_nx;
            if (launch) begin
                wr_addr   <= base_addr;
                remaining <= len_m1;
            end else if (xfer) begin
                wr_addr   <= wr_addr + 1'b1;
                remaining <= (remaining != '0) ? remaining - 1'b1 : remaining;
            end
        end

    always_comb begin
        state_nx = state;
        unique case (state)
            LDR_IDLE: if (start) state_nx = LDR_LOAD;
            LDR_LOAD: begin
                if (abort)                         state_nx = LDR_IDLE;
                else if (xfer && remaining == '0)  state_nx = LDR_DONE;
            end
            default:  state_nx = LDR_IDLE;
        endcase
    end

`ifdef PROG_MEM_LOADER_CSUM_EN
    logic [DW-1:0] csum_q;

    always_ff @(posedge CLK or posedge RESET)
        if (RESET)       csum_q <= '0;
        else if (launch) csum_q <= '0;
        else if (xfer)   csum_q <= csum_q + in_data;

    assign csum = csum_q;
`else
    assign csum = '0;
`endif

    prog_mem_ram #(.AW(AW), .DW(DW)) u_ram (
        .CLK (CLK),
        .we  (xfer),
        .wa  (wr_addr),
        .wd  (in_data),
        .ra  (rd_addr),
        .rd  (rd_data)
    );

endmodule

// File: tb/tb_prog_mem_loader.sv
// tb_prog_mem_loader: directed scoreboard bench for prog_mem_loader.
// Expected values are queued by the stimulus and checked by negedge monitors.
module tb_prog_mem_loader;

    logic        CLK = 1'b0, RESET = 1'b1, start = 1'b0, abort = 1'b0, in_valid = 1'b0;
    logic [11:0] base_addr = '0, len_m1 = '0, rd_addr = '0, wr_addr;
    logic [7:0]  in_data = '0, rd_data, csum;
    logic        in_ready, busy, done;

    int vectors = 0, miscompares = 0;

    localparam int K_RD = 0, K_WA = 1, K_BUSY = 2, K_RDY = 3, K_DONE = 4, K_CS = 5;

    typedef struct { int kind; logic [11:0] exp; string name; } chk_t;
    typedef struct { logic [11:0] wa; logic [7:0] cs; } done_t;

    chk_t  chk_q[$];
    done_t done_q[$];
    chk_t  cur;
    done_t dcur;
    logic [11:0] act;

    logic [7:0] t1[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] t2[4] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    logic [7:0] t3[3] = '{8'hB0, 8'hB1, 8'hB2};
    logic       p3[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] t5[5] = '{8'hE0, 8'hE1, 8'hE2, 8'hE3, 8'hE4};

    always #5 CLK = ~CLK;

    prog_mem_loader dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .start     (start),
        .base_addr (base_addr),
        .len_m1    (len_m1),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .busy      (busy),
        .done      (done),
        .wr_addr   (wr_addr),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .csum      (csum)
    );

    function automatic logic [7:0] cs(input logic [7:0] v);
`ifdef PROG_MEM_LOADER_CSUM_EN
        return v;
`else
        return 8'h00;
`endif
    endfunction

    function automatic logic [11:0] sample(input int k);
        case (k)
            K_RD:    return {4'h0, rd_data};
            K_WA:    return wr_addr;
            K_BUSY:  return {11'h0, busy};
            K_RDY:   return {11'h0, in_ready};
            K_DONE:  return {11'h0, done};
            default: return {4'h0, csum};
        endcase
    endfunction

    always @(negedge CLK) begin
        while (chk_q.size() > 0) begin
            cur = chk_q.pop_front();
            act = sample(cur.kind);
            vectors++;
            if (act !== cur.exp) begin
                miscompares++;
                $display("FAIL %s: got %h want %h", cur.name, act, cur.exp);
            end
        end
        if (done === 1'b1) begin
            vectors++;
            if (done_q.size() == 0) begin
                miscompares++;
                $display("FAIL done_unexpected: got done=1 want done=0 (wr_addr %h)", wr_addr);
            end else begin
                dcur = done_q.pop_front();
                if (wr_addr !== dcur.wa || csum !== dcur.cs) begin
                    miscompares++;
                    $display("FAIL done_state: got wr_addr %h csum %h want wr_addr %h csum %h",
                             wr_addr, csum, dcur.wa, dcur.cs);
                end
            end
        end
    end

    task automatic chk(input int k, input logic [11:0] e, input string n);
        chk_t c;
        c.kind = k;
        c.exp  = e;
        c.name = n;
        chk_q.push_back(c);
    endtask

    task automatic sync();
        @(negedge CLK);
        #1;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_done(input logic [11:0] wa, input logic [7:0] c);
        done_t d;
        d.wa = wa;
        d.cs = c;
        done_q.push_back(d);
    endtask

    task automatic begin_load(input logic [11:0] b, input logic [11:0] l);
        start     = 1'b1;
        base_addr = b;
        len_m1    = l;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
    endtask

    task automatic rd(input logic [11:0] a, input logic [7:0] e, input string n);
        rd_addr = a;
        chk(K_RD, {4'h0, e}, n);
        sync();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end within time limit");
        $fatal(1);
    end

    initial begin
        #1;
        chk(K_BUSY, 0, "reset_busy");
        chk(K_RDY, 0, "reset_in_ready");
        chk(K_DONE, 0, "reset_done");
        chk(K_WA, 0, "reset_wr_addr");
        chk(K_CS, 0, "reset_csum");
        sync();
        tick();
        RESET = 1'b0;
        tick();

        // back-to-back load of 4 bytes at 0
        expect_done(12'h004, cs(8'hAA));
        begin_load(12'h000, 12'd3);
        chk(K_RDY, 1, "t1_in_ready");
        chk(K_BUSY, 1, "t1_busy");
        sync();
        for (int i = 0; i < 4; i++) send(t1[i]);
        in_valid = 1'b0;
        chk(K_DONE, 1, "t1_done_pulse");
        chk(K_RDY, 0, "t1_done_in_ready");
        chk(K_BUSY, 0, "t1_done_busy");
        sync();
        tick();
        chk(K_DONE, 0, "t1_done_cleared");
        chk(K_WA, 12'h004, "t1_wr_addr");
        chk(K_CS, {4'h0, cs(8'hAA)}, "t1_csum");
        sync();
        for (int i = 0; i < 4; i++) rd(12'(i), t1[i], "t1_mem");

        // wrap-around from 0xFFE
        expect_done(12'h002, cs(8'h86));
        begin_load(12'hFFE, 12'd3);
        for (int i = 0; i < 4; i++) send(t2[i]);
        in_valid = 1'b0;
        tick();
        chk(K_WA, 12'h002, "t2_wr_addr");
        sync();
        rd(12'hFFE, 8'hA0, "t2_mem_ffe");
        rd(12'hFFF, 8'hA1, "t2_mem_fff");
        rd(12'h000, 8'hA2, "t2_mem_000");
        rd(12'h001, 8'hA3, "t2_mem_001");

        // gapped stream with len_m1=2
        expect_done(12'h303, cs(8'h13));
        begin_load(12'h300, 12'd2);
        begin
            int k;
            k = 0;
            for (int i = 0; i < 6; i++) begin
                in_valid = p3[i];
                in_data  = p3[i] ? t3[k] : 8'hFF;
                tick();
                if (p3[i]) k++;
                if (i < 5) begin
                    chk(K_BUSY, 1, "t3_busy_held");
                    sync();
                end
            end
        end
        in_valid = 1'b0;
        chk(K_DONE, 1, "t3_done_pulse");
        chk(K_BUSY, 0, "t3_busy_dropped");
        sync();
        tick();
        for (int i = 0; i < 3; i++) rd(12'h300 + 12'(i), t3[i], "t3_mem");

        // abort on the 2nd byte at 0x100, start ignored during LOAD
        expect_done(12'h102, cs(8'hB5));
        begin_load(12'h100, 12'd1);
        send(8'h5A);
        send(8'h5B);
        in_valid = 1'b0;
        tick();
        begin_load(12'h100, 12'd3);
        send(8'hC0);
        in_valid  = 1'b0;
        start     = 1'b1;
        base_addr = 12'h700;
        len_m1    = 12'd0;
        tick();
        start = 1'b0;
        chk(K_WA, 12'h101, "t4_start_ignored_wr_addr");
        chk(K_BUSY, 1, "t4_start_ignored_busy");
        sync();
        abort = 1'b1;
        send(8'hC1);
        abort    = 1'b0;
        in_valid = 1'b0;
        chk(K_BUSY, 0, "t4_abort_busy");
        chk(K_DONE, 0, "t4_abort_no_done");
        chk(K_RDY, 0, "t4_abort_in_ready");
        chk(K_WA, 12'h101, "t4_abort_wr_addr");
        chk(K_CS, {4'h0, cs(8'hC0)}, "t4_abort_csum");
        sync();
        tick();
        chk(K_BUSY, 0, "t4_idle_after_abort");
        sync();
        rd(12'h100, 8'hC0, "t4_mem_100");
        rd(12'h101, 8'h5B, "t4_mem_101_unchanged");

        // async reset mid-load at 0x020
        begin_load(12'h020, 12'd4);
        send(8'hD0);
        send(8'hD1);
        in_valid = 1'b0;
        RESET    = 1'b1;
        chk(K_BUSY, 0, "t5_reset_busy");
        chk(K_RDY, 0, "t5_reset_in_ready");
        chk(K_WA, 0, "t5_reset_wr_addr");
        chk(K_CS, 0, "t5_reset_csum");
        chk(K_DONE, 0, "t5_reset_done");
        sync();
        tick();
        RESET = 1'b0;
        rd(12'h020, 8'hD0, "t5_mem_020_kept");
        rd(12'h021, 8'hD1, "t5_mem_021_kept");
        expect_done(12'h025, cs(8'h6A));
        begin_load(12'h020, 12'd4);
        for (int i = 0; i < 5; i++) send(t5[i]);
        in_valid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) rd(12'h020 + 12'(i), t5[i], "t5_reload_mem");

        // read-during-write at address 5
        expect_done(12'h006, cs(8'hC3));
        begin_load(12'h004, 12'd1);
        send(8'h61);
        send(8'h62);
        in_valid = 1'b0;
        tick();
        expect_done(12'h006, cs(8'h77));
        begin_load(12'h005, 12'd0);
        rd_addr  = 12'h005;
        in_valid = 1'b1;
        in_data  = 8'h77;
        chk(K_RD, 12'h062, "t6_rd_old_before_edge");
        sync();
        tick();
        in_valid = 1'b0;
        chk(K_RD, 12'h077, "t6_rd_new_after_edge");
        chk(K_DONE, 1, "t6_done_pulse");
        sync();
        rd(12'h004, 8'h61, "t6_rd_other_addr");

        tick();
        tick();
        if (done_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL done_missing: got %0d pending done pulses want 0", done_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
